// File: rtl/bram_wr_sched.sv
// Round-robin burst write scheduler for a BRAM port A that is split into two halves, one per producer.
// Each half keeps its own wrapping write pointer; port-A outputs are registered one cycle after acceptance.
module bram_wr_sched #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clr0,
    input  logic                  clr1,
    output logic                  EN_A,
    output logic                  WE_A,
    output logic [ADDR_WIDTH-1:0] ADDR_A,
    output logic [DATA_WIDTH-1:0] DIN_A,
    output logic                  wrap0,
    output logic                  wrap1
);

    localparam int PW = ADDR_WIDTH - 1;
    localparam int BW = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr0_q, ptr0_d;
    logic [PW-1:0]           ptr1_q, ptr1_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    last_grant_q, last_grant_d;
    logic                    en_q, en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    wrap0_q, wrap0_d;
    logic                    wrap1_q, wrap1_d;

    logic                    xfer0, xfer1, burst_end;
    logic [PW-1:0]           wr_off;

    assign req0_ready = (state_q == GRANT0);
    assign req1_ready = (state_q == GRANT1);
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign burst_end  = (beat_q == BW'(BURST_LEN - 1));

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // On contention the requester that was not served last wins.
                if (req0_valid && (!req1_valid || last_grant_q)) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                    beat_d       = '0;
                end else if (req1_valid) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                    beat_d       = '0;
                end
            end
            GRANT0: begin
                if (!req0_valid) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    if (burst_end) state_d = IDLE;
                end
            end
            GRANT1: begin
                if (!req1_valid) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    if (burst_end) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear coinciding with a transfer writes the beat at offset 0 and leaves the pointer at 1.
    always_comb begin
        ptr0_d = ptr0_q;
        ptr1_d = ptr1_q;
        if (clr0)       ptr0_d = xfer0 ? PW'(1) : '0;
        else if (xfer0) ptr0_d = ptr0_q + 1'b1;
        if (clr1)       ptr1_d = xfer1 ? PW'(1) : '0;
        else if (xfer1) ptr1_d = ptr1_q + 1'b1;
    end

    always_comb begin
        wr_off  = xfer1 ? (clr1 ? '0 : ptr1_q) : (clr0 ? '0 : ptr0_q);
        en_d    = xfer0 || xfer1;
        addr_d  = en_d ? {xfer1, wr_off} : addr_q;
        din_d   = xfer1 ? req1_data : (xfer0 ? req0_data : din_q);
        wrap0_d = xfer0 && (&wr_off);
        wrap1_d = xfer1 && (&wr_off);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr0_q       <= '0;
            ptr1_q       <= '0;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
            en_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            wrap0_q      <= 1'b0;
            wrap1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr0_q       <= ptr0_d;
            ptr1_q       <= ptr1_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            wrap0_q      <= wrap0_d;
            wrap1_q      <= wrap1_d;
        end
    end

    assign EN_A   = en_q;
    assign WE_A   = en_q;
    assign ADDR_A = addr_q;
    assign DIN_A  = din_q;
    assign wrap0  = wrap0_q;
    assign wrap1  = wrap1_q;

endmodule

// File: tb/tb_bram_wr_sched.sv
// Directed bench for bram_wr_sched: a per-cycle vector table for handoff/clear corners,
// plus loops for single-stream bursts, contention, region wrap and asynchronous reset.
module tb_bram_wr_sched;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        clr0, clr1;
    logic        EN_A, WE_A, wrap0, wrap1;
    logic [10:0] ADDR_A;
    logic [15:0] DIN_A;

    int n_checks = 0;
    int n_pass   = 0;

    bram_wr_sched dut (
        .CLK(CLK), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr0(clr0), .clr1(clr1),
        .EN_A(EN_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DIN_A(DIN_A),
        .wrap0(wrap0), .wrap1(wrap1)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        c0;
        logic        c1;
        logic [1:0]  rdy;   // {req1_ready, req0_ready} before the edge
        logic [3:0]  ctl;   // {EN_A, WE_A, wrap0, wrap1} after the edge
        logic [10:0] addr;
        logic [15:0] din;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = '0;   req1_data  = '0;
        clr0       = 1'b0; clr1       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset_ctl",  {28'd0, EN_A, WE_A, wrap0, wrap1}, 32'd0);
        chk("reset_addr", {21'd0, ADDR_A}, 32'd0);
        chk("reset_din",  {16'd0, DIN_A}, 32'd0);
        chk("reset_rdy",  {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // ---------------- table: valid drop, handoff, clears, contention after idle ----------------
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 16'hA000, 1'b0, 1'b0, 2'b00, 4'b0000, 11'h000, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 16'hA001, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h400, 16'hA001};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 16'hA002, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h401, 16'hA002};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 16'hA003, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h402, 16'hA003};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 16'hA004, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h403, 16'hA004};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 16'hA005, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h404, 16'hA005};
        tbl[6]  = '{1'b1, 16'hB000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b10, 4'b0000, 11'h404, 16'hA005};
        tbl[7]  = '{1'b1, 16'hB000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 4'b0000, 11'h404, 16'hA005};
        tbl[8]  = '{1'b1, 16'hB001, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b01, 4'b1100, 11'h000, 16'hB001};
        tbl[9]  = '{1'b1, 16'hB002, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b01, 4'b1100, 11'h000, 16'hB002};
        tbl[10] = '{1'b1, 16'hB003, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b01, 4'b1100, 11'h001, 16'hB003};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 2'b01, 4'b0000, 11'h001, 16'hB003};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 16'hC000, 1'b0, 1'b0, 2'b00, 4'b0000, 11'h001, 16'hB003};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 16'hC001, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h400, 16'hC001};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 16'hC002, 1'b0, 1'b1, 2'b10, 4'b1100, 11'h400, 16'hC002};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 16'hC003, 1'b0, 1'b0, 2'b10, 4'b1100, 11'h401, 16'hC003};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b10, 4'b0000, 11'h401, 16'hC003};
        tbl[17] = '{1'b1, 16'hD000, 1'b1, 16'hE000, 1'b0, 1'b0, 2'b00, 4'b0000, 11'h401, 16'hC003};
        tbl[18] = '{1'b1, 16'hD001, 1'b1, 16'hE001, 1'b0, 1'b0, 2'b01, 4'b1100, 11'h002, 16'hD001};

        for (int i = 0; i < 19; i++) begin
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
            clr0       = tbl[i].c0; clr1      = tbl[i].c1;
            chk("tbl_rdy", {30'd0, req1_ready, req0_ready}, {30'd0, tbl[i].rdy});
            tick();
            chk("tbl_ctl",  {28'd0, EN_A, WE_A, wrap0, wrap1}, {28'd0, tbl[i].ctl});
            chk("tbl_addr", {21'd0, ADDR_A}, {21'd0, tbl[i].addr});
            chk("tbl_din",  {16'd0, DIN_A},  {16'd0, tbl[i].din});
            $display("vec %0d: rdy=%b%b en=%0b addr=%0d din=%04h", i, req1_ready, req0_ready,
                     EN_A, ADDR_A, DIN_A);
        end

        // ---------------- single stream: 40 beats, bubbles after beats 16 and 32 ----------------
        do_reset();
        begin
            int idx = 0;
            for (int c = 0; c < 43; c++) begin
                bit exp_rdy;
                exp_rdy    = !(c == 0 || c == 17 || c == 34);
                req0_valid = 1'b1;
                req0_data  = 16'(idx + 1);
                chk("ss_rdy", {31'd0, req0_ready}, {31'd0, exp_rdy});
                tick();
                chk("ss_en", {31'd0, EN_A}, {31'd0, exp_rdy});
                if (exp_rdy) begin
                    chk("ss_addr", {21'd0, ADDR_A}, idx);
                    chk("ss_din",  {16'd0, DIN_A}, idx + 1);
                    $display("ss beat %0d: addr=%0d din=%04h", idx + 1, ADDR_A, DIN_A);
                    idx++;
                end
            end
            chk("ss_beats", idx, 40);
        end

        // ---------------- asynchronous reset in the middle of a burst ----------------
        req0_valid = 1'b1;
        req0_data  = 16'h0029;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ctl",  {28'd0, EN_A, WE_A, wrap0, wrap1}, 32'd0);
        chk("arst_addr", {21'd0, ADDR_A}, 32'd0);
        chk("arst_din",  {16'd0, DIN_A}, 32'd0);
        chk("arst_rdy",  {30'd0, req1_ready, req0_ready}, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_en",  {31'd0, EN_A}, 32'd0);
            chk("post_rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
        end

        // ---------------- contention: alternating 16-beat bursts ----------------
        do_reset();
        for (int c = 0; c < 68; c++) begin
            int ph, b;
            ph = c % 17;
            b  = c / 17;
            req0_valid = 1'b1; req0_data = 16'(16'h1000 + c);
            req1_valid = 1'b1; req1_data = 16'(16'h2000 + c);
            chk("ct_rdy", {30'd0, req1_ready, req0_ready},
                (ph == 0) ? 32'd0 : ((b % 2 == 0) ? 32'd1 : 32'd2));
            tick();
            chk("ct_en", {31'd0, EN_A}, (ph == 0) ? 32'd0 : 32'd1);
            if (ph != 0) begin
                chk("ct_addr", {21'd0, ADDR_A}, ((b % 2) * 1024) + (b / 2) * 16 + ph - 1);
                chk("ct_din",  {16'd0, DIN_A}, ((b % 2 == 0) ? 32'h1000 : 32'h2000) + c);
                $display("ct cycle %0d: grant%0d addr=%0d din=%04h", c, b % 2, ADDR_A, DIN_A);
            end
        end

        // ---------------- region-0 wrap after 1024 beats ----------------
        do_reset();
        begin
            int n = 0;
            for (int c = 0; c < 1200 && n < 1025; c++) begin
                bit exp_rdy;
                exp_rdy    = (c % 17) != 0;
                req0_valid = 1'b1;
                req0_data  = 16'(n);
                chk("wr_rdy", {31'd0, req0_ready}, {31'd0, exp_rdy});
                tick();
                if (exp_rdy) begin
                    chk("wr_addr",  {21'd0, ADDR_A}, n % 1024);
                    chk("wr_wrap0", {31'd0, wrap0}, (n == 1023) ? 32'd1 : 32'd0);
                    chk("wr_wrap1", {31'd0, wrap1}, 32'd0);
                    if (n >= 1022)
                        $display("wr beat %0d: addr=%0d wrap0=%0b wrap1=%0b", n, ADDR_A, wrap0, wrap1);
                    n++;
                end
            end
            chk("wr_beats", n, 1025);
        end

        idle_inputs();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_wr_sched.md
# bram_wr_sched

Write-side scheduler for the shared 2048-deep weight BRAM port A. Two independent producers each own one half of the BRAM (requester 0: addresses 0–1023, requester 1: 1024–2047). The block arbitrates between them round-robin in bursts, generates the port-A address, write enable and data with one cycle of latency, and keeps a wrapping write pointer per region. It sits between the producer streams and the BRAM primitive, replacing a free-running single-stream address counter.

## Interface
- ADDR_WIDTH, 11, BRAM address width; region size is 2^(ADDR_WIDTH-1).
- DATA_WIDTH, 16, write data width.
- BURST_LEN, 16, maximum beats per grant before re-arbitration (power of two, ≥2).

- CLK  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a beat
- req0_data  in  DATA_WIDTH  requester 0 beat data
- req0_ready  out  1  requester 0 beat accepted this cycle when valid
- req1_valid  in  1  requester 1 has a beat
- req1_data  in  DATA_WIDTH  requester 1 beat data
- req1_ready  out  1  requester 1 beat accepted this cycle when valid
- clr0  in  1  synchronous clear of region-0 pointer
- clr1  in  1  synchronous clear of region-1 pointer
- EN_A  out  1  BRAM port-A enable, registered
- WE_A  out  1  BRAM port-A write enable, registered
- ADDR_A  out  ADDR_WIDTH  BRAM port-A address, registered
- DIN_A  out  DATA_WIDTH  BRAM port-A write data, registered
- wrap0  out  1  one-cycle pulse: region-0 last offset written
- wrap1  out  1  one-cycle pulse: region-1 last offset written

## Operation
- States: IDLE, GRANT0, GRANT1. Internal: ptr0, ptr1 (ADDR_WIDTH-1 bits), beat counter, last_grant.
- reqN_ready = (state == GRANTN); combinational from state only, never from valid.
- Transfer on N = reqN_valid && reqN_ready.
- IDLE: if only one valid, go to that GRANT. If both valid, go to GRANT of the requester ≠ last_grant. If none, stay. On entry to GRANTN: last_grant ← N, beat counter ← 0.
- GRANTN: each transfer increments the beat counter.
  - Transfer with beat counter == BURST_LEN-1: go to IDLE.
  - reqN_valid low: go to IDLE (no transfer that cycle).
  - Otherwise stay.
- Write on transfer N: next cycle EN_A=WE_A=1, ADDR_A={N, ptrN}, DIN_A=reqN_data. ptrN ← ptrN+1, wrapping from 2^(ADDR_WIDTH-1)-1 to 0.
- wrapN=1 in the same cycle as WE_A for the beat written at offset 2^(ADDR_WIDTH-1)-1.
- With no transfer, EN_A=WE_A=0. ADDR_A and DIN_A hold their last value.
- clrN without a transfer: ptrN ← 0.
- clrN with a simultaneous transfer N: clear wins. The beat is written at offset 0 and ptrN ← 1.
- clr of the non-granted region does not affect the current burst.

## Timing
- Reset (async assert, sync to CLK deassert path not required): state=IDLE, ptr0=ptr1=0, last_grant=1 (requester 0 wins first contention), beat counter=0.
- Output reset values: EN_A=0, WE_A=0, ADDR_A=0, DIN_A=0, wrap0=wrap1=0, req0_ready=req1_ready=0.
- Latency: transfer at edge k → BRAM write visible on outputs from edge k to edge k+1.
- Arbitration bubble: exactly one IDLE cycle between the end of a grant and the next grant; no ready is asserted in IDLE.
- Peak throughput: BURST_LEN beats per BURST_LEN+1 cycles per contending pair.
- Reset mid-burst: outputs drop to reset values immediately on rst assertion. An in-flight registered write is discarded and pointers return to 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 before the next edge; after release with no valid, EN_A stays 0 and the FSM stays IDLE.
- Single stream: req0_valid held high with 40 beats, data 0x0001..0x0028 → writes at ADDR_A 0..39 in order, DIN_A matching. One idle cycle after beats 16 and 32, req0_ready low on those cycles.
- Contention: both valid continuously from reset → grants alternate 0,1,0,1 in 16-beat bursts. Region 1 addresses run 1024..1039 then 1040..1055.
- Wrap: pre-load region 0 with 1023 beats, then 2 more beats → the beat written at ADDR_A=1023 has wrap0=1, the following beat lands at ADDR_A=0, and wrap1 stays 0.
- Clear collision: ptr1=500, clr1 asserted on the same edge as a req1 transfer of 0xBEEF → write at ADDR_A=1024 with 0xBEEF; the next beat goes to 1025.
- Valid drop: requester 1 deasserts valid after 5 beats of a grant → FSM returns to IDLE, and a pending requester 0 is granted two cycles later.
